// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial (LSB-first) unsigned subtractor.
// Computes diff = a - b - bin mod 2^WIDTH and bout = (a < b + bin), one bit
// per clock, using WIDTH SHIFT cycles followed by a single DONE cycle.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // Counter only needs to reach WIDTH-1; keep it at least one bit wide.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] d_sr_reg;
  logic             br_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;

  logic             a_bit, b_bit;
  logic             d_bit;
  logic             br_next;
  logic             last_bit;

  // One full-subtractor slice acting on the current LSBs and running borrow.
  always_comb begin
    a_bit    = a_sr_reg[0];
    b_bit    = b_sr_reg[0];
    d_bit    = a_bit ^ b_bit ^ br_reg;
    br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);
    last_bit = (cnt_reg == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and status outputs; DONE always lasts exactly one cycle.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: load operands on accept, shift one bit per SHIFT cycle, and
  // publish the assembled result only on the final shift so diff/bout stay
  // stable while the next operation is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      a_sr_reg <= '0;
      b_sr_reg <= '0;
      d_sr_reg <= '0;
      br_reg   <= 1'b0;
      diff_reg <= '0;
      bout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            cnt_reg  <= '0;
            a_sr_reg <= a;
            b_sr_reg <= b;
            d_sr_reg <= '0;
            br_reg   <= bin;
          end
        end
        SHIFT: begin
          cnt_reg  <= cnt_reg + CW'(1);
          a_sr_reg <= {1'b0, a_sr_reg[WIDTH-1:1]};
          b_sr_reg <= {1'b0, b_sr_reg[WIDTH-1:1]};
          // Result bits enter at the MSB so after WIDTH shifts bit 0 is at LSB.
          d_sr_reg <= {d_bit, d_sr_reg[WIDTH-1:1]};
          br_reg   <= br_next;
          if (last_bit) begin
            diff_reg <= {d_bit, d_sr_reg[WIDTH-1:1]};
            bout_reg <= br_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff = diff_reg;
  assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard-based bench for serial_subtractor (WIDTH=4).
// Expected {bout,diff} are queued when an operation is launched and popped by
// a monitor whenever done is observed.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W:0] expq[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference: plain integer subtraction, independent of the bit-serial form.
  function automatic logic [W:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rbin);
    int          full;
    logic [W-1:0] d;
    logic         bo;
    full = int'(ra) - int'(rb) - int'(rbin);
    d    = W'(full & ((1 << W) - 1));
    bo   = (full < 0);
    return {bo, d};
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest pending result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      logic [W:0] exp_v;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got diff=%h bout=%b, required no done pulse", diff, bout);
      end else begin
        exp_v = expq.pop_front();
        if ({bout, diff} !== exp_v) begin
          errors++;
          $display("FAIL result: got diff=%h bout=%b, required diff=%h bout=%b",
                   diff, bout, exp_v[W-1:0], exp_v[W]);
        end else begin
          $display("op ok: diff=%h bout=%b", diff, bout);
        end
      end
    end
  end

  // Launch one operation, scramble operands after acceptance, wait for done.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    int n;
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    bin   = tbin;
    start = 1'b1;
    expq.push_back(ref_model(ta, tb_v, tbin));
    @(negedge clk);
    start = 1'b0;
    a     = ~ta;
    b     = ~tb_v;
    bin   = ~tbin;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL op_timeout: got no done after %0d cycles, required done within 20", n);
      expq.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    #2;
    checks++;
    if ({busy, done, bout, diff} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b bout=%b diff=%h, required all 0",
               busy, done, bout, diff);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b, required 0", busy);
    end
  endtask

  // a=9,b=3: busy for 5 cycles, done seen 5 cycles after acceptance, stable diff.
  task automatic test_basic();
    int n, busy_cnt, done_at;
    logic [W-1:0] prev;
    @(negedge clk);
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    expq.push_back(ref_model(4'd9, 4'd3, 1'b0));
    prev = diff;
    busy_cnt = 0;
    done_at  = 0;
    n        = 0;
    @(negedge clk);
    start = 1'b0;
    a = 4'd1; b = 4'd1;
    n = 1;
    while (busy && n < 20) begin
      busy_cnt++;
      if (done && done_at == 0) done_at = n;
      if (!done && diff !== prev) begin
        checks++;
        errors++;
        $display("FAIL diff_hold: got %h during SHIFT, required %h", diff, prev);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy_cnt != W + 1) begin
      errors++;
      $display("FAIL busy_len: got %0d cycles, required %0d", busy_cnt, W + 1);
    end
    checks++;
    if (done_at != W + 1) begin
      errors++;
      $display("FAIL done_latency: got %0d, required %0d", done_at, W + 1);
    end
  endtask

  task automatic test_vectors();
    do_op(4'd3, 4'd9, 1'b0);
    do_op(4'd5, 4'd5, 1'b0);
    do_op(4'd0, 4'd0, 1'b1);
    do_op(4'd15, 4'd15, 1'b1);
    do_op(4'd0, 4'd15, 1'b0);
  endtask

  // start re-pulsed with other operands during SHIFT must be ignored.
  task automatic test_ignore_start();
    int n;
    @(negedge clk);
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    expq.push_back(ref_model(4'd9, 4'd3, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL ignore_timeout: got no done, required one");
      expq.delete();
    end
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_second_op: got busy=%b, required 0", busy);
    end
  endtask

  // Reset in the 2nd SHIFT cycle clears outputs at once and aborts the op.
  task automatic test_midreset();
    @(negedge clk);
    a = 4'd12; b = 4'd2; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (diff === '0) begin
      errors++;
      $display("FAIL midreset_pre: got diff=%h, required nonzero from previous op", diff);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, bout, diff} !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b bout=%b diff=%h, required all 0",
               busy, done, bout, diff);
    end
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({busy, diff} !== '0) begin
      errors++;
      $display("FAIL abort: got busy=%b diff=%h, required 0 and 0", busy, diff);
    end
    do_op(4'd15, 4'd1, 1'b0);
  endtask

  // start held high: three ops accepted in consecutive IDLE cycles, 6 apart.
  task automatic test_back_to_back();
    int pushed, seen, n;
    int dcyc[3];
    logic [W-1:0] va[3];
    logic [W-1:0] vb[3];
    logic         vc[3];
    va = '{4'd7, 4'd2, 4'd14};
    vb = '{4'd4, 4'd11, 4'd14};
    vc = '{1'b1, 1'b0, 1'b1};
    pushed = 0;
    seen   = 0;
    n      = 0;
    while (seen < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (done) begin
        dcyc[seen] = cyc;
        seen++;
      end
      if (!busy && pushed < 3) begin
        a = va[pushed]; b = vb[pushed]; bin = vc[pushed]; start = 1'b1;
        expq.push_back(ref_model(va[pushed], vb[pushed], vc[pushed]));
        pushed++;
      end else if (busy && pushed == 3) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (seen != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses, required 3", seen);
      expq.delete();
    end else begin
      checks++;
      if (dcyc[1] - dcyc[0] != 6 || dcyc[2] - dcyc[1] != 6) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d and %0d, required 6 and 6",
                 dcyc[1] - dcyc[0], dcyc[2] - dcyc[1]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_exhaustive();
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 16; j++) begin
        do_op(W'(i & 15), W'(j), i[4]);
      end
    end
    for (int k = 0; k < 20; k++) begin
      do_op(W'($urandom_range(15)), W'($urandom_range(15)), 1'($urandom_range(1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_midreset();
    test_back_to_back();
    test_exhaustive();
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
